// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file slave.
package i2c_pkg;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;
    localparam int         BYTE_BITS          = 8;
    localparam int         NREGS              = 4;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into clk and turns bus transitions into registered one-clk event pulses.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sh;
    logic [SYNC_STAGES-1:0] sda_sh;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_now;
    logic                   sda_now;

    assign scl_now = scl_sh[SYNC_STAGES-1];
    assign sda_now = sda_sh[SYNC_STAGES-1];
    // sda_d holds the value that produced the current pulse, so bits sampled on scl_rise line up.
    assign sda_s   = sda_d;

    // Reset to an idle (released) bus so leaving reset never fakes an edge or START.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sh   <= '1;
            sda_sh   <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_sh   <= {scl_sh[SYNC_STAGES-2:0], scl};
            sda_sh   <= {sda_sh[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_now;
            sda_d    <= sda_now;
            scl_rise <= scl_now & ~scl_d;
            scl_fall <= ~scl_now & scl_d;
            start    <= scl_now & scl_d & sda_d & ~sda_now;
            stop     <= scl_now & scl_d & ~sda_d & sda_now;
        end
    end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave with a 4 x 8-bit auto-incrementing register file; registers 1:0 drive the LED bus.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] leds,
    output logic        busy,
    output logic        wr_strobe,
    output logic [3:0]  dbg_state
);

    localparam logic [3:0] LAST_BIT = 4'(BYTE_BITS);

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shifter;
    logic [1:0]  ptr;
    logic [1:0]  ptr_next;
    logic [7:0]  regs [NREGS];
    logic        sda_oe;
    logic        rw;
    logic        scl_rise;
    logic        scl_fall;
    logic        start;
    logic        stop;
    logic        sda_s;

    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign ptr_next  = ptr + 2'd1;
    assign dbg_state = 4'(state);

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shifter   <= 8'h00;
            ptr       <= 2'd0;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            leds      <= 16'h0000;
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            leds      <= {regs[1], regs[0]};
            // Bus conditions win over any scl edge seen in the same clk.
            if (start) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && bit_cnt != LAST_BIT) begin
                            shifter <= {shifter[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == LAST_BIT) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR) begin
                                if (shifter[7:1] == SLAVE_ADDR) begin
                                    rw     <= shifter[0];
                                    sda_oe <= 1'b1;
                                    state  <= ADDR_ACK;
                                end else begin
                                    state  <= WAIT_STOP;
                                end
                            end else if (state == PTR) begin
                                ptr    <= shifter[1:0];
                                sda_oe <= 1'b1;
                                state  <= PTR_ACK;
                            end else begin
                                regs[ptr] <= shifter;
                                wr_strobe <= 1'b1;
                                ptr       <= ptr_next;
                                sda_oe    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shifter <= regs[ptr];
                                sda_oe  <= ~regs[ptr][7];
                                state   <= RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                state   <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == LAST_BIT) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= RACK;
                            end else begin
                                shifter <= {shifter[6:0], 1'b0};
                                sda_oe  <= ~shifter[6];
                            end
                        end
                    end
                    // bit_cnt==1 here records that the master ACKed on the 9th rise.
                    RACK: begin
                        if (scl_rise) begin
                            if (sda_s) state <= WAIT_STOP;
                            else       bit_cnt <= 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            ptr     <= ptr_next;
                            shifter <= regs[ptr_next];
                            sda_oe  <= ~regs[ptr_next][7];
                            bit_cnt <= 4'd0;
                            state   <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged master against a register-file reference model.
module tb_i2c_slave_regs;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scl = 1'b1;
    logic        m_oe = 1'b0;
    wire         sda;
    logic [15:0] leds;
    logic        busy;
    logic        wr_strobe;
    logic [3:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int low_cnt = 0;

    logic [7:0] ref_regs [4];
    int         ref_ptr;
    logic [7:0] wq [$];
    logic [7:0] rq [$];
    logic [7:0] exp_q [$];

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    i2c_slave_regs dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .leds      (leds),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_strobe) strobe_cnt++;
    always @(negedge clk) if (!m_oe && sda === 1'b0) low_cnt++;

    // ---------------- driver tasks ----------------
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_oe = 1'b0; wait_q();
        scl  = 1'b1; wait_q();
        m_oe = 1'b1; wait_q();
        scl  = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1; wait_q();
        scl  = 1'b1; wait_q();
        m_oe = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            m_oe = ~b[7-i]; wait_q();
            scl  = 1'b1;    wait_q();
            wait_q();
            scl  = 1'b0;    wait_q();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        write_bits(b, 8);
        m_oe = 1'b0; wait_q();
        scl  = 1'b1; wait_q();
        ack  = sda;  wait_q();
        scl  = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] b, output logic ninth);
        m_oe = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            scl  = 1'b1; wait_q();
            b[i] = sda;  wait_q();
            scl  = 1'b0; wait_q();
        end
        m_oe  = give_ack; wait_q();
        scl   = 1'b1;     wait_q();
        ninth = sda;      wait_q();
        scl   = 1'b0;     wait_q();
    endtask

    // ---------------- reference model + transactions ----------------
    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        ref_ptr = 0;
    endtask

    // Write transaction: pointer byte then every byte in wq; counts NACKs seen.
    task automatic xfer_write(input logic [7:0] p, output int nacks);
        logic a;
        nacks = 0;
        i2c_start();
        write_byte(8'hA0, a); nacks += int'(a);
        write_byte(p, a);     nacks += int'(a);
        ref_ptr = int'(p) % 4;
        foreach (wq[i]) begin
            write_byte(wq[i], a); nacks += int'(a);
            ref_regs[ref_ptr] = wq[i];
            ref_ptr = (ref_ptr + 1) % 4;
        end
        i2c_stop();
        wq.delete();
    endtask

    // Read transaction of n bytes from the current pointer: ACK all but the last.
    task automatic xfer_read(input int n, output int nacks);
        logic a;
        logic [7:0] b;
        logic ninth;
        nacks = 0;
        i2c_start();
        write_byte(8'hA1, a); nacks += int'(a);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, b, ninth);
            rq.push_back(b);
            exp_q.push_back(ref_regs[ref_ptr]);
            if (i != n - 1) ref_ptr = (ref_ptr + 1) % 4;
        end
        i2c_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; scl = 1'b1; m_oe = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL reset_leds got=%h exp=0000", leds); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got=%b exp=1(released)", sda); end
        checks++; if (dbg_state !== 4'(IDLE)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        reset = 1'b1;
        repeat (10) @(negedge clk);
        model_reset();
    endtask

    task automatic test_write();
        logic a;
        logic [7:0] bytes [4];
        int s0;
        bytes[0] = 8'hA0; bytes[1] = 8'h00; bytes[2] = 8'h3C; bytes[3] = 8'hC3;
        s0 = strobe_cnt;
        i2c_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_start got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], a);
            checks++; if (a !== 1'b0) begin errors++; $display("FAIL write_ack%0d got=%b exp=0", i, a); end
        end
        i2c_stop();
        ref_regs[0] = 8'h3C; ref_regs[1] = 8'hC3; ref_ptr = 2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
        checks++; if (strobe_cnt - s0 != 2) begin errors++; $display("FAIL write_strobes got=%0d exp=2", strobe_cnt - s0); end
        checks++; if (leds !== 16'hC33C) begin errors++; $display("FAIL write_leds got=%h exp=c33c", leds); end
    endtask

    task automatic test_read_rstart();
        logic a;
        logic [7:0] b;
        logic ninth;
        logic [7:0] e;
        i2c_start();
        write_byte(8'hA0, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL read_addr_w_ack got=%b exp=0", a); end
        write_byte(8'h01, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL read_ptr_ack got=%b exp=0", a); end
        ref_ptr = 1;
        i2c_start();
        write_byte(8'hA1, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL read_addr_r_ack got=%b exp=0", a); end
        e = ref_regs[ref_ptr];
        read_byte(1'b1, b, ninth);
        checks++; if (b !== e) begin errors++; $display("FAIL read_byte0 got=%h exp=%h", b, e); end
        ref_ptr = (ref_ptr + 1) % 4;
        e = ref_regs[ref_ptr];
        read_byte(1'b0, b, ninth);
        checks++; if (b !== e) begin errors++; $display("FAIL read_byte1 got=%h exp=%h", b, e); end
        checks++; if (ninth !== 1'b1) begin errors++; $display("FAIL read_nack_slot got=%b exp=1", ninth); end
        wait_q();
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL read_release got=%b exp=1", sda); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic verify_regs(input string tag);
        int n;
        wq.delete();
        xfer_write(8'h00, n);
        checks++; if (n != 0) begin errors++; $display("FAIL %s_setptr_nacks got=%0d exp=0", tag, n); end
        xfer_read(4, n);
        checks++; if (n != 0) begin errors++; $display("FAIL %s_read_nacks got=%0d exp=0", tag, n); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] g, e;
            g = rq.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL %s_reg%0d got=%h exp=%h", tag, i, g, e); end
        end
    endtask

    task automatic test_ptr_wrap();
        int n;
        wq = '{8'h11, 8'h22};
        xfer_write(8'h03, n);
        checks++; if (n != 0) begin errors++; $display("FAIL wrap_nacks got=%0d exp=0", n); end
        checks++; if (leds !== 16'hC322) begin errors++; $display("FAIL wrap_leds got=%h exp=c322", leds); end
        verify_regs("wrap");
    endtask

    task automatic test_wrong_addr();
        logic a;
        int s0, l0;
        logic [15:0] led0;
        s0 = strobe_cnt; l0 = low_cnt; led0 = {ref_regs[1], ref_regs[0]};
        i2c_start();
        write_byte(8'hA2, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL wrong_addr_ack got=%b exp=1", a); end
        write_byte(8'h00, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL wrong_data_ack got=%b exp=1", a); end
        i2c_stop();
        checks++; if (low_cnt != l0) begin errors++; $display("FAIL wrong_sda_low got=%0d exp=0 clks", low_cnt - l0); end
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL wrong_strobe got=%0d exp=0", strobe_cnt - s0); end
        checks++; if (leds !== led0) begin errors++; $display("FAIL wrong_leds got=%h exp=%h", leds, led0); end
        verify_regs("wrong");
    endtask

    task automatic test_abort_stop();
        logic a;
        int s0;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h02, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL abort_ptr_ack got=%b exp=0", a); end
        ref_ptr = 2;
        write_bits(8'($urandom_range(0, 255)), 4);
        i2c_stop();
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL abort_strobe got=%0d exp=0", strobe_cnt - s0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        verify_regs("abort");
    endtask

    task automatic test_abort_reset();
        logic a;
        int n;
        // Reset while the slave is driving its address ACK.
        i2c_start();
        write_bits(8'hA0, 8);
        m_oe = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rst_ack_driven got=%b exp=0", sda); end
        reset = 1'b0; #1;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_ack_release got=%b exp=1", sda); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        model_reset();
        i2c_stop();
        // Reset in the middle of a data byte.
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h01, a);
        write_bits(8'hA5, 4);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL rst_mid_leds got=%h exp=0000", leds); end
        checks++; if (dbg_state !== 4'(IDLE)) begin errors++; $display("FAIL rst_mid_state got=%0d exp=%0d", dbg_state, IDLE); end
        reset = 1'b1;
        model_reset();
        i2c_stop();
        wq = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        xfer_write(8'h00, n);
        checks++; if (n != 0) begin errors++; $display("FAIL rst_next_nacks got=%0d exp=0", n); end
        verify_regs("rst");
    endtask

    task automatic test_random();
        int n, nb, nr;
        logic [7:0] p;
        for (int t = 0; t < 5; t++) begin
            p  = 8'($urandom_range(0, 255));
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) wq.push_back(8'($urandom_range(0, 255)));
            xfer_write(p, n);
            checks++; if (n != 0) begin errors++; $display("FAIL rnd%0d_w_nacks got=%0d exp=0", t, n); end
            checks++; if (leds !== {ref_regs[1], ref_regs[0]}) begin
                errors++; $display("FAIL rnd%0d_leds got=%h exp=%h", t, leds, {ref_regs[1], ref_regs[0]});
            end
            nr = $urandom_range(1, 4);
            xfer_read(nr, n);
            checks++; if (n != 0) begin errors++; $display("FAIL rnd%0d_r_nacks got=%0d exp=0", t, n); end
            while (exp_q.size() > 0) begin
                logic [7:0] g, e;
                g = rq.pop_front(); e = exp_q.pop_front();
                checks++; if (g !== e) begin errors++; $display("FAIL rnd%0d_rdata got=%h exp=%h", t, g, e); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write();
        test_read_rstart();
        test_ptr_wrap();
        test_wrong_addr();
        test_abort_stop();
        test_abort_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
